// File: rtl/sigmadelta_pkg.sv
// ============================================================================
//  sigmadelta_pkg
//  Shared types for the multi-channel sigma-delta DAC: gain-ramp FSM state
//  encoding and a width-generic saturation helper for the modulators.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package sigmadelta_pkg;

    typedef enum logic [1:0] {
        ST_MUTED     = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_ACTIVE    = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } gain_state_t;

    // Clamp v to the symmetric range +/-(2^(w-1)-1). The most-negative code of
    // a w-bit word is deliberately excluded so the range stays symmetric.
    function automatic logic signed [31:0] sat(input logic signed [31:0] v,
                                               input int                 w);
        logic signed [31:0] lim;
        lim = (32'sd1 <<< (w - 1)) - 32'sd1;
        if (v > lim) begin
            return lim;
        end else if (v < -lim) begin
            return -lim;
        end else begin
            return v;
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/sigmadelta_dac_mc_if.sv
// ============================================================================
//  sigmadelta_dac_mc_if
//  Sample/mute input bundle and 1-bit outputs of the multi-channel DAC.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface sigmadelta_dac_mc_if #(
    parameter int CHANNELS   = 2,
    parameter int AUDIO_BITS = 10
);
    logic                           sample_en;
    logic [CHANNELS*AUDIO_BITS-1:0] d;
    logic                           mute;
    logic [CHANNELS-1:0]            q;
    logic                           muted;

    // Audio source side
    modport master (
        output sample_en, d, mute,
        input  q, muted
    );

    // DAC side
    modport slave (
        input  sample_en, d, mute,
        output q, muted
    );
endinterface

`default_nettype wire

// File: rtl/sigmadelta_mod.sv
// ============================================================================
//  sigmadelta_mod
//  One channel's 1st- or 2nd-order sigma-delta modulator, running every clk.
//  Input x is signed; output q is a registered 1-bit stream whose density of
//  ones tracks (x + 2^(AUDIO_BITS-1)) / 2^AUDIO_BITS.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module sigmadelta_mod
    import sigmadelta_pkg::*;
#(
    parameter int AUDIO_BITS = 10,
    parameter int ORDER      = 2
) (
    input  wire logic                         clk,
    input  wire logic                         rst_n,
    input  wire logic signed [AUDIO_BITS-1:0] x,
    output logic                              q
);

    if (ORDER == 1) begin : g_ord1
        // The AUDIO_BITS+1-bit accumulator is held as acc_q (low bits) plus
        // q_q (its carry bit), which is also the registered output.
        logic [AUDIO_BITS-1:0] acc_q;
        logic                  q_q;
        logic [AUDIO_BITS-1:0] w_u;
        logic [AUDIO_BITS:0]   w_acc_d;

        assign w_u     = {~x[AUDIO_BITS-1], x[AUDIO_BITS-2:0]};
        assign w_acc_d = {1'b0, acc_q} + {1'b0, w_u};

        // First-order accumulate; carry out is the output bit
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc_q <= '0;
                q_q   <= 1'b0;
            end else begin
                acc_q <= w_acc_d[AUDIO_BITS-1:0];
                q_q   <= w_acc_d[AUDIO_BITS];
            end
        end

        assign q = q_q;
    end else if (ORDER == 2) begin : g_ord2
        localparam int                 IW = AUDIO_BITS + 3;
        localparam logic signed [31:0] FS = 32'sd1 <<< (AUDIO_BITS - 1);

        logic signed [IW-1:0] i1_q;
        logic signed [IW-1:0] i2_q;
        logic                 q_q;
        logic signed [31:0]   w_fb;
        logic signed [31:0]   w_i1_sum;
        logic signed [31:0]   w_i2_sum;
        logic signed [IW-1:0] w_i1_d;
        logic signed [IW-1:0] w_i2_d;

        // Sums are formed at 32 bits so saturation sees the true value and the
        // integrators can never wrap.
        assign w_fb     = q_q ? FS : -FS;
        assign w_i1_sum = 32'(i1_q) + 32'(x) - w_fb;
        assign w_i2_sum = 32'(i2_q) + 32'(i1_q) - w_fb;
        assign w_i1_d   = IW'(sat(w_i1_sum, IW));
        assign w_i2_d   = IW'(sat(w_i2_sum, IW));

        // Two cascaded saturating integrators; output is the sign of next i2
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                i1_q <= '0;
                i2_q <= '0;
                q_q  <= 1'b0;
            end else begin
                i1_q <= w_i1_d;
                i2_q <= w_i2_d;
                q_q  <= ~w_i2_d[IW-1];
            end
        end

        assign q = q_q;
    end else begin : g_bad_order
        $error("sigmadelta_mod: ORDER must be 1 or 2");
        assign q = 1'b0;
    end

endmodule

`default_nettype wire

// File: rtl/sigmadelta_dac_mc.sv
// ============================================================================
//  sigmadelta_dac_mc
//  Multi-channel sigma-delta audio DAC: per-channel zero-order-hold sample
//  registers, a shared click-free mute/unmute gain ramp, per-channel gain
//  multipliers and one modulator per channel.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module sigmadelta_dac_mc
    import sigmadelta_pkg::*;
#(
    parameter int CHANNELS   = 2,
    parameter int AUDIO_BITS = 10,
    parameter int ORDER      = 2,
    parameter int GAIN_BITS  = 6
) (
    input wire logic            clk,
    input wire logic            rst_n,
    sigmadelta_dac_mc_if.slave  bus
);

    localparam int             GW        = GAIN_BITS + 1;
    localparam int             PW        = AUDIO_BITS + GAIN_BITS + 1;
    localparam logic [GW-1:0]  GAIN_FULL = {1'b1, {GAIN_BITS{1'b0}}};
    localparam logic [GW-1:0]  GAIN_ONE  = GW'(1);

    gain_state_t         state_q;
    logic [GW-1:0]       gain_q;
    logic                muted_q;
    logic [CHANNELS-1:0] w_q;

    // Gain ramp FSM: advances only on sample strobes, one gain step per strobe.
    // A direction reversal changes state but holds gain for that strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_MUTED;
            gain_q  <= '0;
            muted_q <= 1'b1;
        end else if (bus.sample_en) begin
            case (state_q)
                ST_MUTED: begin
                    if (!bus.mute) begin
                        state_q <= ST_RAMP_UP;
                        gain_q  <= gain_q + GAIN_ONE;
                        muted_q <= 1'b0;
                    end
                end
                ST_RAMP_UP: begin
                    if (bus.mute) begin
                        state_q <= ST_RAMP_DOWN;
                    end else begin
                        gain_q <= gain_q + GAIN_ONE;
                        if (gain_q + GAIN_ONE == GAIN_FULL) begin
                            state_q <= ST_ACTIVE;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (bus.mute) begin
                        state_q <= ST_RAMP_DOWN;
                        gain_q  <= gain_q - GAIN_ONE;
                    end
                end
                ST_RAMP_DOWN: begin
                    if (!bus.mute) begin
                        state_q <= ST_RAMP_UP;
                    end else begin
                        gain_q <= gain_q - GAIN_ONE;
                        if (gain_q == GAIN_ONE) begin
                            state_q <= ST_MUTED;
                            muted_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_MUTED;
                    gain_q  <= '0;
                    muted_q <= 1'b1;
                end
            endcase
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic signed [AUDIO_BITS-1:0] s_q;
        logic signed [AUDIO_BITS-1:0] x_q;
        logic signed [PW-1:0]         w_prod;

        // Gain is non-negative, so it is zero-extended before the signed multiply
        assign w_prod = PW'(s_q) * PW'($signed({1'b0, gain_q}));

        // Zero-order hold of this channel's sample
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s_q <= '0;
            end else if (bus.sample_en) begin
                s_q <= bus.d[c*AUDIO_BITS +: AUDIO_BITS];
            end
        end

        // Scaled sample, arithmetic shift rounds toward -inf
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                x_q <= '0;
            end else begin
                x_q <= AUDIO_BITS'(w_prod >>> GAIN_BITS);
            end
        end

        sigmadelta_mod #(
            .AUDIO_BITS (AUDIO_BITS),
            .ORDER      (ORDER)
        ) u_mod (
            .clk   (clk),
            .rst_n (rst_n),
            .x     (x_q),
            .q     (w_q[c])
        );
    end

    assign bus.q     = w_q;
    assign bus.muted = muted_q;

endmodule

`default_nettype wire

// File: tb/tb_sigmadelta_dac_mc.sv
// ============================================================================
//  tb_sigmadelta_dac_mc
//  Directed self-checking bench: an ORDER=2 and an ORDER=1 instance driven
//  with identical stimulus (CHANNELS=2, AUDIO_BITS=10, GAIN_BITS=6).
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sigmadelta_dac_mc;
    import sigmadelta_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        sample_en;
    logic [19:0] d;
    logic        mute;

    int checks   = 0;
    int failures = 0;
    int sat_viol = 0;

    sigmadelta_dac_mc_if #(.CHANNELS(2), .AUDIO_BITS(10)) bus2 ();
    sigmadelta_dac_mc_if #(.CHANNELS(2), .AUDIO_BITS(10)) bus1 ();

    assign bus2.sample_en = sample_en;
    assign bus2.d         = d;
    assign bus2.mute      = mute;
    assign bus1.sample_en = sample_en;
    assign bus1.d         = d;
    assign bus1.mute      = mute;

    sigmadelta_dac_mc #(.CHANNELS(2), .AUDIO_BITS(10), .ORDER(2), .GAIN_BITS(6)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    sigmadelta_dac_mc #(.CHANNELS(2), .AUDIO_BITS(10), .ORDER(1), .GAIN_BITS(6)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=[%0d..%0d]", tag, obs, lo, hi);
        end
    endtask

    // One strobe, then enough clocks for the scaled sample to register
    task automatic strobe();
        @(negedge clk) sample_en = 1'b1;
        @(negedge clk) sample_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic strobes(input int n);
        for (int k = 0; k < n; k++) strobe();
    endtask

    task automatic set_d(input logic signed [9:0] ch0, input logic signed [9:0] ch1);
        d = {ch1, ch0};
    endtask

    // Count ones per channel per instance over n clocks; also watch the
    // ORDER=2 integrators for the unreachable most-negative 13-bit code.
    task automatic run_count(input int n, output int c2a, output int c2b,
                             output int c1a, output int c1b);
        c2a = 0; c2b = 0; c1a = 0; c1b = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            c2a += int'(bus2.q[0]);
            c2b += int'(bus2.q[1]);
            c1a += int'(bus1.q[0]);
            c1b += int'(bus1.q[1]);
            if (u_dut2.g_ch[0].u_mod.g_ord2.i1_q < -13'sd4095 ||
                u_dut2.g_ch[0].u_mod.g_ord2.i2_q < -13'sd4095 ||
                u_dut2.g_ch[1].u_mod.g_ord2.i1_q < -13'sd4095 ||
                u_dut2.g_ch[1].u_mod.g_ord2.i2_q < -13'sd4095)
                sat_viol++;
        end
    endtask

    initial begin
        int c2a, c2b, c1a, c1b;
        rst_n     = 1'b0;
        sample_en = 1'b0;
        mute      = 1'b1;
        d         = '0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("rst_q2", 32'(bus2.q), 0);
        check("rst_q1", 32'(bus1.q), 0);
        check("rst_muted", 32'(bus2.muted), 1);
        check("rst_gain", 32'(u_dut2.gain_q), 0);
        check("rst_state", 32'(u_dut2.state_q), 32'(ST_MUTED));
        @(negedge clk) rst_n = 1'b1;

        // ---------------- ramp up ----------------
        set_d(10'sd511, 10'sd511);
        mute = 1'b0;
        strobe();
        check("up_muted_s1", 32'(bus2.muted), 0);
        check("up_gain_s1", 32'(u_dut2.gain_q), 1);
        check("up_x_s1", u_dut2.g_ch[0].x_q, 7);      // 511*1>>>6
        strobes(62);
        check("up_x_s63", u_dut2.g_ch[0].x_q, 503);   // 511*63>>>6
        check("up_state_s63", 32'(u_dut2.state_q), 32'(ST_RAMP_UP));
        strobe();
        check("up_x_s64", u_dut2.g_ch[1].x_q, 511);
        check("up_state_s64", 32'(u_dut2.state_q), 32'(ST_ACTIVE));
        strobes(6);
        check("up_gain_s70", 32'(u_dut2.gain_q), 64);
        check("up_state_s70", 32'(u_dut2.state_q), 32'(ST_ACTIVE));

        // ---------------- density +256 and silence ----------------
        set_d(10'sd256, 10'sd256);
        strobe();
        repeat (256) @(negedge clk);
        run_count(4096, c2a, c2b, c1a, c1b);
        check_range("dens256_o2", c2a, 3064, 3080);
        check_range("dens256_o1", c1a, 3064, 3080);

        set_d(10'sd0, 10'sd0);
        strobe();
        repeat (256) @(negedge clk);
        run_count(4096, c2a, c2b, c1a, c1b);
        check_range("dens0_o2", c2a, 2040, 2056);
        check_range("dens0_o1", c1a, 2040, 2056);

        // ---------------- channel independence ----------------
        set_d(10'sd200, -10'sd200);
        strobe();
        check("ind_x0", u_dut2.g_ch[0].x_q, 200);
        check("ind_x1", u_dut2.g_ch[1].x_q, -200);
        repeat (256) @(negedge clk);
        run_count(4096, c2a, c2b, c1a, c1b);
        check_range("ind_ch0_o2", c2a, 2807, 2889);
        check_range("ind_ch1_o2", c2b, 1207, 1289);
        check_range("ind_ch0_o1", c1a, 2807, 2889);
        check_range("ind_ch1_o1", c1b, 1207, 1289);
        strobe();
        check("ind_same_x1", u_dut2.g_ch[1].x_q, -200);
        check("ind_same_gain", 32'(u_dut2.gain_q), 64);

        // ---------------- extremes ----------------
        set_d(-10'sd512, -10'sd512);
        strobe();
        check("ext_neg_x", u_dut2.g_ch[0].x_q, -512);
        repeat (256) @(negedge clk);
        run_count(8192, c2a, c2b, c1a, c1b);
        check_range("ext_neg_o2", c2a, 0, 16);
        check("ext_neg_o1", c1a, 0);

        set_d(10'sd511, 10'sd511);
        strobe();
        repeat (256) @(negedge clk);
        run_count(8192, c2a, c2b, c1a, c1b);
        check_range("ext_pos_o2", c2b, 8168, 8192);
        check_range("ext_pos_o1", c1b, 8168, 8192);
        check("ext_sat_bound", sat_viol, 0);

        // ---------------- full ramp down ----------------
        mute = 1'b1;
        strobe();
        check("dn_gain_s1", 32'(u_dut2.gain_q), 63);
        check("dn_state_s1", 32'(u_dut2.state_q), 32'(ST_RAMP_DOWN));
        strobes(62);
        check("dn_muted_s63", 32'(bus2.muted), 0);
        strobe();
        check("dn_muted_s64", 32'(bus1.muted), 1);
        check("dn_gain_s64", 32'(u_dut2.gain_q), 0);
        check("dn_x_s64", u_dut2.g_ch[0].x_q, 0);

        // ---------------- frozen without strobes ----------------
        mute = 1'b0;
        repeat (10) @(negedge clk);
        check("frz_state", 32'(u_dut2.state_q), 32'(ST_MUTED));
        check("frz_muted", 32'(bus2.muted), 1);

        // ---------------- mid-ramp reversal ----------------
        strobes(20);
        check("rev_gain20", 32'(u_dut2.gain_q), 20);
        mute = 1'b1;
        strobe();
        check("rev_hold_gain", 32'(u_dut2.gain_q), 20);
        check("rev_hold_state", 32'(u_dut2.state_q), 32'(ST_RAMP_DOWN));
        strobes(19);
        check("rev_gain1", 32'(u_dut2.gain_q), 1);
        check("rev_muted19", 32'(bus2.muted), 0);
        strobe();
        check("rev_gain0", 32'(u_dut2.gain_q), 0);
        check("rev_muted20", 32'(bus2.muted), 1);

        // ---------------- async reset while ACTIVE ----------------
        mute = 1'b0;
        strobes(64);
        check("act_state", 32'(u_dut2.state_q), 32'(ST_ACTIVE));
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_q2", 32'(bus2.q), 0);
        check("arst_q1", 32'(bus1.q), 0);
        check("arst_muted", 32'(bus2.muted), 1);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("arst_state", 32'(u_dut2.state_q), 32'(ST_MUTED));
        check("arst_gain", 32'(u_dut2.gain_q), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
